binary_median_window_engine: RTL and testbench
==============================================

// Module: binary_median_window_engine
// PURPOSE
//  Parametrised successor to the fixed 3x3 binary median reader. Scans a WIN x WIN window over an
//  IMG_W x IMG_H 1-bit image held in external memory, one pixel per cycle, with configurable memory
//  read latency. Emits one binary median pixel per valid (interior) window position, with coordinates.
//  Sits between the image BRAM (read port) and the median result memory (write port).
// PARAMETERS
//  IMG_W   128  image width in pixels (>= WIN)
//  IMG_H   128  image height in pixels (>= WIN)
//  ADDR_W  8    width of x/y address buses; 2**ADDR_W >= max(IMG_W, IMG_H)
//  WIN     3    window side, odd, 3..7
//  RD_LAT  1    memory read latency in clocks, 1..4 (dataIn valid RD_LAT cycles after rdEn)
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       asynchronous, active-low reset
//  start         in   1       level; sampled in IDLE only; launches a full-image scan
//  init          in   1       clears DONE -> IDLE; ignored in other states
//  xAddressOut   out  ADDR_W  pixel column being read
//  yAddressOut   out  ADDR_W  pixel row being read
//  rdEn          out  1       address valid this cycle
//  dataIn        in   1       pixel returned RD_LAT cycles after rdEn
//  medianDataOut out  1       median of current window (1 iff ones > WIN*WIN/2)
//  medianValid   out  1       one-cycle strobe qualifying medianDataOut/outX/outY
//  outX, outY    out  ADDR_W  window top-left coordinate of the emitted median
//  busy          out  1       high in FETCH/DRAIN/EMIT
//  fullImageDone out  1       high while in DONE
// BEHAVIOUR
//  Reset (async, active-low): state IDLE; all outputs 0; all counters 0; sum 0; in-flight pipe flushed.
//  States: IDLE -> FETCH (start=1) ; FETCH -> DRAIN after WIN*WIN reads issued ;
//   DRAIN -> EMIT once RD_LAT cycles after the final read have elapsed ; EMIT -> FETCH (next window) or
//   DONE (last window) ; DONE -> IDLE (init=1).
//  FETCH: one rdEn per cycle, window pixels column-major within window:
//   x = winX + colCnt, y = winY + rowCnt; rowCnt increments first, wraps 0 at WIN-1 and increments colCnt.
//  Return path: a RD_LAT-deep shift register of rdEn; when its tail is 1, sum <= sum + dataIn.
//   sum width = $clog2(WIN*WIN+1); cannot overflow. sum cleared entering FETCH.
//  EMIT (one cycle): medianDataOut <= (sum > (WIN*WIN)/2); medianValid <= 1; outX/outY <= winX/winY.
//   medianDataOut/outX/outY hold until the next EMIT; medianValid is a single-cycle pulse.
//  Window order: winX 0..IMG_W-WIN, then winY increments; last window is
//   (IMG_W-WIN, IMG_H-WIN). Total emits = (IMG_W-WIN+1)*(IMG_H-WIN+1). No border outputs.
//  Cycles per window = WIN*WIN + RD_LAT + 1 (FETCH + DRAIN + EMIT), fixed.
//  start high during non-IDLE states: ignored (no restart). init in non-DONE states: ignored.
//  start and init both high in DONE: init wins -> IDLE; start only acted on next cycle from IDLE.
//  DONE held until init; fullImageDone rises the cycle after the last EMIT.
//  Reset asserted mid-scan: immediate return to IDLE, no partial medianValid after release.
//  dataIn is ignored whenever the return-pipe tail is 0 (X on dataIn must not corrupt sum).
//  WIN=IMG_W=IMG_H: exactly one window, one emit, then DONE.
// TESTING
//  1 WIN=3, 8x8 all-ones, RD_LAT=1 -> 36 medianValid pulses, all medianDataOut=1, last outX=outY=5, then fullImageDone.
//  2 WIN=3, window at (0,0) with exactly 4 ones -> medianDataOut=0; with 5 ones -> 1 (threshold boundary).
//  3 WIN=5, RD_LAT=3, 5x5 image, checkerboard (13 ones) -> single emit, medianDataOut=1, outX=outY=0,
//    emit 29 cycles after FETCH entry; no second pulse.
//  4 Address sequence, WIN=3, first window: (x,y)=(0,0),(0,1),(0,2),(1,0)..(2,2), rdEn 9 consecutive cycles.
//  5 Drop reset low at window 10 of 36 -> all outputs 0 next edge; after release + start, scan restarts at (0,0).
//  6 start held high through DONE with init pulse -> IDLE then new scan; init during FETCH has no effect.
//  Scoreboard: reference model of random 16x16 image (WIN=3,5,7; RD_LAT=1..4) matches every emit.

Source files
------------

// File: rtl/binary_median_window_engine.sv
// binary_median_window_engine
//   Scans a WIN x WIN window across an IMG_W x IMG_H 1-bit image held in an
//   external memory. It reads one pixel per cycle and emits one binary median
//   (1 iff ones > WIN*WIN/2) for every interior window position.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   start          level; launches a full-image scan when sampled in IDLE
//   init           returns DONE to IDLE; ignored elsewhere
//   xAddressOut    pixel column being read
//   yAddressOut    pixel row being read
//   rdEn           address valid this cycle
//   dataIn         pixel returned RD_LAT cycles after rdEn
//   medianDataOut  median of the last emitted window
//   medianValid    one-cycle strobe qualifying medianDataOut/outX/outY
//   outX, outY     top-left coordinate of the emitted window
//   busy           high in FETCH/DRAIN/EMIT
//   fullImageDone  high while in DONE
module binary_median_window_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 8,
  parameter int WIN    = 3,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              init,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  output logic              rdEn,
  input  logic              dataIn,
  output logic              medianDataOut,
  output logic              medianValid,
  output logic [ADDR_W-1:0] outX,
  output logic [ADDR_W-1:0] outY,
  output logic              busy,
  output logic              fullImageDone
);

  localparam int NPIX  = WIN * WIN;
  localparam int CNT_W = $clog2(WIN);
  localparam int SUM_W = $clog2(NPIX + 1);
  localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIN - 1);
  localparam logic [ADDR_W-1:0] LAST_X   = ADDR_W'(IMG_W - WIN);
  localparam logic [ADDR_W-1:0] LAST_Y   = ADDR_W'(IMG_H - WIN);
  localparam logic [SUM_W-1:0]  HALF     = SUM_W'(NPIX / 2);
  localparam logic [DRN_W-1:0]  LAST_DRN = DRN_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    EMIT,
    DONE
  } stateT;

  stateT             state;
  logic [ADDR_W-1:0] winX;
  logic [ADDR_W-1:0] winY;
  logic [CNT_W-1:0]  rowCnt;
  logic [CNT_W-1:0]  colCnt;
  logic [DRN_W-1:0]  drainCnt;
  logic [SUM_W-1:0]  sum;
  logic [RD_LAT-1:0] retPipe;

  // Delayed copy of rdEn; the tail marks the cycle in which dataIn is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retPipe <= '0;
    end else begin
      retPipe[0] <= rdEn;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        retPipe[i] <= retPipe[i-1];
      end
    end
  end

  // The address outputs are registered, so each transition loads the address
  // of the read issued in the following cycle rather than the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      winX          <= '0;
      winY          <= '0;
      rowCnt        <= '0;
      colCnt        <= '0;
      drainCnt      <= '0;
      sum           <= '0;
      xAddressOut   <= '0;
      yAddressOut   <= '0;
      rdEn          <= 1'b0;
      medianDataOut <= 1'b0;
      medianValid   <= 1'b0;
      outX          <= '0;
      outY          <= '0;
      busy          <= 1'b0;
      fullImageDone <= 1'b0;
    end else begin
      medianValid <= 1'b0;
      // Only accumulate when a read is actually returning; dataIn is a
      // don't-care otherwise.
      if (retPipe[RD_LAT-1]) begin
        sum <= sum + SUM_W'(dataIn);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            rdEn        <= 1'b1;
            winX        <= '0;
            winY        <= '0;
            rowCnt      <= '0;
            colCnt      <= '0;
            xAddressOut <= '0;
            yAddressOut <= '0;
            sum         <= '0;
          end
        end

        FETCH: begin
          if (rowCnt == LAST_IDX) begin
            rowCnt <= '0;
            if (colCnt == LAST_IDX) begin
              state    <= DRAIN;
              rdEn     <= 1'b0;
              colCnt   <= '0;
              drainCnt <= '0;
            end else begin
              colCnt      <= colCnt + 1'b1;
              xAddressOut <= winX + ADDR_W'(colCnt + 1'b1);
              yAddressOut <= winY;
            end
          end else begin
            rowCnt      <= rowCnt + 1'b1;
            yAddressOut <= winY + ADDR_W'(rowCnt + 1'b1);
          end
        end

        DRAIN: begin
          if (drainCnt == LAST_DRN) begin
            state <= EMIT;
          end else begin
            drainCnt <= drainCnt + 1'b1;
          end
        end

        EMIT: begin
          medianDataOut <= (sum > HALF);
          medianValid   <= 1'b1;
          outX          <= winX;
          outY          <= winY;
          if (winX == LAST_X && winY == LAST_Y) begin
            state         <= DONE;
            busy          <= 1'b0;
            fullImageDone <= 1'b1;
          end else begin
            state  <= FETCH;
            rdEn   <= 1'b1;
            sum    <= '0;
            rowCnt <= '0;
            colCnt <= '0;
            if (winX == LAST_X) begin
              winX        <= '0;
              winY        <= winY + 1'b1;
              xAddressOut <= '0;
              yAddressOut <= winY + 1'b1;
            end else begin
              winX        <= winX + 1'b1;
              xAddressOut <= winX + 1'b1;
              yAddressOut <= winY;
            end
          end
        end

        DONE: begin
          if (init) begin
            state         <= IDLE;
            fullImageDone <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_median_window_engine.sv
module tb_binary_median_window_engine;

  localparam int NI = 5;

  function automatic int cfgW(input int i);
    if (i == 0) return 8;
    if (i == 1) return 5;
    return 16;
  endfunction

  function automatic int cfgWin(input int i);
    if (i == 0 || i == 2) return 3;
    if (i == 1 || i == 3) return 5;
    return 7;
  endfunction

  function automatic int cfgLat(input int i);
    if (i == 0) return 1;
    if (i == 1) return 3;
    if (i == 2) return 2;
    if (i == 3) return 4;
    return 3;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rstV, startV, initV, rdEnV, dataV, medV, mvV, busyV, doneV;
  logic [7:0] xA[NI], yA[NI], oX[NI], oY[NI];

  bit   img[NI][16][16];
  logic dq[NI][4];
  int   cyc = 0;

  int   emCnt[NI];
  logic [7:0] emX[NI][1024];
  logic [7:0] emY[NI][1024];
  logic emM[NI][1024];
  int   emCyc[NI][1024];
  int   doneRiseCyc[NI];
  bit   prevDone[NI];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < NI; g++) begin : gDut
    binary_median_window_engine #(
      .IMG_W (cfgW(g)),
      .IMG_H (cfgW(g)),
      .ADDR_W(8),
      .WIN   (cfgWin(g)),
      .RD_LAT(cfgLat(g))
    ) dut (
      .clk          (clk),
      .reset        (rstV[g]),
      .start        (startV[g]),
      .init         (initV[g]),
      .xAddressOut  (xA[g]),
      .yAddressOut  (yA[g]),
      .rdEn         (rdEnV[g]),
      .dataIn       (dataV[g]),
      .medianDataOut(medV[g]),
      .medianValid  (mvV[g]),
      .outX         (oX[g]),
      .outY         (oY[g]),
      .busy         (busyV[g]),
      .fullImageDone(doneV[g])
    );
    assign dataV[g] = dq[g][cfgLat(g)-1];
  end

  // Memory model: data for an address read in cycle c appears in cycle c+lat.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      dq[i][0] <= rdEnV[i] ? img[i][yA[i][3:0]][xA[i][3:0]] : 1'bx;
      for (int k = 1; k < 4; k++) dq[i][k] <= dq[i][k-1];
    end
  end

  // Emit recorder.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mvV[i] === 1'b1) begin
        if (emCnt[i] < 1024) begin
          emX[i][emCnt[i]]   <= oX[i];
          emY[i][emCnt[i]]   <= oY[i];
          emM[i][emCnt[i]]   <= medV[i];
          emCyc[i][emCnt[i]] <= cyc;
        end
        emCnt[i] <= emCnt[i] + 1;
      end
      prevDone[i] <= (doneV[i] === 1'b1);
      if (doneV[i] === 1'b1 && !prevDone[i]) doneRiseCyc[i] <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkIdleZero(input int i, input string tag);
    chk({tag, "_x"}, 32'(xA[i]), 0);
    chk({tag, "_y"}, 32'(yA[i]), 0);
    chk({tag, "_rdEn"}, 32'(rdEnV[i]), 0);
    chk({tag, "_med"}, 32'(medV[i]), 0);
    chk({tag, "_mv"}, 32'(mvV[i]), 0);
    chk({tag, "_outX"}, 32'(oX[i]), 0);
    chk({tag, "_outY"}, 32'(oY[i]), 0);
    chk({tag, "_busy"}, 32'(busyV[i]), 0);
    chk({tag, "_done"}, 32'(doneV[i]), 0);
  endtask

  task automatic startScan(input int i);
    startV[i] = 1'b1;
    @(negedge clk);
    startV[i] = 1'b0;
  endtask

  task automatic endScan(input int i, input string tag);
    initV[i] = 1'b1;
    @(negedge clk);
    initV[i] = 1'b0;
    chk({tag, "_doneCleared"}, 32'(doneV[i]), 0);
    chk({tag, "_idleBusy"}, 32'(busyV[i]), 0);
  endtask

  task automatic waitDone(input int i, input int budget, input string tag);
    int n = 0;
    while (doneV[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_doneReached"}, 32'(doneV[i]), 1);
  endtask

  // First window read order: column-major, rowCnt fastest.
  task automatic chkFirstReads(input int i, input string tag);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s_rd%0d_en", tag, k), 32'(rdEnV[i]), 1);
      chk($sformatf("%s_rd%0d_x", tag, k), 32'(xA[i]), 32'(k / 3));
      chk($sformatf("%s_rd%0d_y", tag, k), 32'(yA[i]), 32'(k % 3));
      @(negedge clk);
    end
    chk({tag, "_rdEnAfter9"}, 32'(rdEnV[i]), 0);
  endtask

  // Reference: windows in raster order of top-left corner, median by count.
  task automatic scanCheck(input int i, input int base, input string tag);
    int w = cfgWin(i);
    int n = cfgW(i) - w + 1;
    int k = base;
    int ones;
    @(negedge clk);
    chk({tag, "_count"}, 32'(emCnt[i] - base), 32'(n * n));
    for (int wy = 0; wy < n; wy++) begin
      for (int wx = 0; wx < n; wx++) begin
        ones = 0;
        for (int dy = 0; dy < w; dy++)
          for (int dx = 0; dx < w; dx++)
            ones += int'(img[i][wy+dy][wx+dx]);
        if (k < emCnt[i] && k < 1024) begin
          chk($sformatf("%s_e%0d_x", tag, k - base), 32'(emX[i][k]), 32'(wx));
          chk($sformatf("%s_e%0d_y", tag, k - base), 32'(emY[i][k]), 32'(wy));
          chk($sformatf("%s_e%0d_med", tag, k - base), 32'(emM[i][k]), 32'(ones > (w * w) / 2));
        end
        k++;
      end
    end
  endtask

  initial begin
    int base;
    int snap;
    int n;

    rstV   = '0;
    startV = '0;
    initV  = '0;
    for (int i = 0; i < NI; i++)
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          img[i][y][x] = 1'b0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        img[0][y][x] = 1'b1;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        img[1][y][x] = ((x + y) % 2 == 0);
    for (int i = 2; i < NI; i++)
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          img[i][y][x] = 1'($urandom_range(0, 1));

    // Reset state
    repeat (3) @(negedge clk);
    chkIdleZero(0, "reset");
    rstV = '1;
    repeat (2) @(negedge clk);
    chk("idle_rdEn", 32'(rdEnV[0]), 0);
    chk("idle_busy", 32'(busyV[0]), 0);

    // All-ones 8x8 image: 36 emits of 1, last at (5,5), done right after
    base = emCnt[0];
    startScan(0);
    chk("t1_busy", 32'(busyV[0]), 1);
    waitDone(0, 600, "t1");
    scanCheck(0, base, "t1");
    chk("t1_lastX", 32'(oX[0]), 5);
    chk("t1_lastY", 32'(oY[0]), 5);
    chk("t1_doneAfterLastEmit", 32'(doneRiseCyc[0]), 32'(emCyc[0][emCnt[0]-1]));
    endScan(0, "t1");

    // Threshold boundary at window (0,0): 4 ones -> 0, 5 ones -> 1
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        img[0][y][x] = 1'b0;
    img[0][0][0] = 1'b1;
    img[0][1][1] = 1'b1;
    img[0][2][2] = 1'b1;
    img[0][2][0] = 1'b1;
    base = emCnt[0];
    startScan(0);
    waitDone(0, 600, "t2a");
    scanCheck(0, base, "t2a");
    chk("t2a_firstMed", 32'(emM[0][base]), 0);
    endScan(0, "t2a");
    img[0][0][2] = 1'b1;
    base = emCnt[0];
    startScan(0);
    waitDone(0, 600, "t2b");
    scanCheck(0, base, "t2b");
    chk("t2b_firstMed", 32'(emM[0][base]), 1);
    endScan(0, "t2b");

    // Address order, then reset mid-scan and restart from (0,0)
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        img[0][y][x] = 1'($urandom_range(0, 1));
    base = emCnt[0];
    startScan(0);
    chkFirstReads(0, "t4");
    n = 0;
    while (emCnt[0] < base + 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached10", 32'(emCnt[0] >= base + 10), 1);
    rstV[0] = 1'b0;
    @(negedge clk);
    chkIdleZero(0, "t5_rst");
    snap = emCnt[0];
    @(negedge clk);
    rstV[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_noPulseAfterRelease", 32'(emCnt[0]), 32'(snap));
    chk("t5_idleAfterRelease", 32'(busyV[0]), 0);
    base = emCnt[0];
    startScan(0);
    chkFirstReads(0, "t5r");
    waitDone(0, 600, "t5r");
    scanCheck(0, base, "t5r");
    endScan(0, "t5r");

    // start held high; init during FETCH ignored; init wins in DONE
    base = emCnt[0];
    startV[0] = 1'b1;
    repeat (3) @(negedge clk);
    initV[0] = 1'b1;
    @(negedge clk);
    initV[0] = 1'b0;
    chk("t6_busyAfterInitInFetch", 32'(busyV[0]), 1);
    waitDone(0, 600, "t6a");
    scanCheck(0, base, "t6a");
    repeat (3) @(negedge clk);
    chk("t6_doneHeldWithStart", 32'(doneV[0]), 1);
    initV[0] = 1'b1;
    @(negedge clk);
    initV[0] = 1'b0;
    chk("t6_idleDone", 32'(doneV[0]), 0);
    chk("t6_idleRdEn", 32'(rdEnV[0]), 0);
    base = emCnt[0];
    @(negedge clk);
    startV[0] = 1'b0;
    chk("t6_restartRdEn", 32'(rdEnV[0]), 1);
    chk("t6_restartX", 32'(xA[0]), 0);
    chk("t6_restartY", 32'(yA[0]), 0);
    waitDone(0, 600, "t6b");
    scanCheck(0, base, "t6b");
    endScan(0, "t6b");

    // 5x5 WIN=5 RD_LAT=3 checkerboard: single emit 29 cycles after FETCH entry
    base = emCnt[1];
    startV[1] = 1'b1;
    @(posedge clk);
    #1 startV[1] = 1'b0;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (mvV[1] === 1'b1) break;
    end
    chk("t3_latency", 32'(n), 29);
    chk("t3_med", 32'(medV[1]), 1);
    chk("t3_outX", 32'(oX[1]), 0);
    chk("t3_outY", 32'(oY[1]), 0);
    @(negedge clk);
    waitDone(1, 100, "t3");
    scanCheck(1, base, "t3");
    repeat (40) @(negedge clk);
    chk("t3_noSecondPulse", 32'(emCnt[1] - base), 1);
    endScan(1, "t3");

    // Random 16x16 scoreboard for WIN=3,5,7
    startV[4:2] = 3'b111;
    @(negedge clk);
    startV[4:2] = 3'b000;
    for (int i = 2; i < NI; i++) begin
      waitDone(i, 8000, $sformatf("sb%0d", i));
      scanCheck(i, 0, $sformatf("sb%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
